// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
//   Groups the keypad pins and the key handshake of keypad_scanner.
//   master : the scanner (drives col_n and the key handshake outputs)
//   slave  : the board/consumer side (drives row_n and key_ack)
//   row_n     4  keypad rows, active-low, pulled up, asynchronous
//   col_n     4  column strobe, active-low one-hot
//   key_code  4  accepted key, row*4 + col
//   key_valid 1  key_code holds an unacknowledged key
//   key_ack   1  consumer acknowledge
//   key_held  1  debounced "a key is currently down"
//   overrun   1  a press was accepted while key_valid was still set
interface keypad_scanner_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_held;
    logic       overrun;

    modport master (
        input  row_n, key_ack,
        output col_n, key_code, key_valid, key_held, overrun
    );

    modport slave (
        output row_n, key_ack,
        input  col_n, key_code, key_valid, key_held, overrun
    );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low keypad one column at a time, debounces over whole
//   scan frames and hands out one key code per press via valid/ack.
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   kp   keypad_scanner_if.master (row_n, col_n, key_code, key_valid,
//        key_ack, key_held, overrun)
//
// state     | meaning
// S_IDLE    | no key accepted, waiting for a single-key frame
// S_DEB     | same single key seen in cnt_q consecutive frames
// S_PRESSED | key accepted and still down
// S_RELEASE | empty frames counted in cnt_q before declaring release
module keypad_scanner #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic            clk,
    input  logic            rst,
    keypad_scanner_if.master kp
);
    localparam int         DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DWELL_TC = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0] DEB_N = 4'(DEBOUNCE);

    typedef enum logic [1:0] {S_IDLE, S_DEB, S_PRESSED, S_RELEASE} state_t;

    logic [3:0]       row_s1_q, row_s2_q;
    logic [DIV_W-1:0] dwell_q;
    logic [1:0]       col_q;
    logic [3:0]       col_n_q;
    logic [15:0]      snap_q, snap_d;
    logic             tick, frame_end;
    logic [4:0]       n_hot;
    logic [3:0]       cand;
    logic             single, none;
    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [3:0]       code_q;
    logic             held_q;
    logic             accept;
    logic [3:0]       key_code_q;
    logic             key_valid_q, overrun_q;

    assign tick      = (dwell_q == DWELL_TC);
    assign frame_end = tick && (col_q == 2'd3);

    // Snapshot as it will look after this tick; at frame end this is the
    // complete frame, including the column being sampled right now.
    always_comb begin
        snap_d = snap_q;
        for (int r = 0; r < 4; r++) begin
            snap_d[{2'(r), col_q}] = ~row_s2_q[r];
        end
    end

    always_comb begin
        n_hot = '0;
        cand  = '0;
        for (int i = 0; i < 16; i++) begin
            if (snap_d[i]) begin
                n_hot = n_hot + 5'd1;
                cand  = 4'(i);
            end
        end
    end

    assign single = (n_hot == 5'd1);
    assign none   = (n_hot == 5'd0);

    assign accept = frame_end && single &&
                    ((state_q == S_IDLE && DEB_N == 4'd1) ||
                     (state_q == S_DEB && cand == code_q && cnt_q + 4'd1 == DEB_N));

    // Row synchronizer, dwell counter, column strobe and frame snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1_q <= 4'hF;
            row_s2_q <= 4'hF;
            dwell_q  <= '0;
            col_q    <= 2'd0;
            col_n_q  <= 4'b1110;
            snap_q   <= '0;
        end else begin
            row_s1_q <= kp.row_n;
            row_s2_q <= row_s1_q;
            if (tick) begin
                dwell_q <= '0;
                col_q   <= col_q + 2'd1;
                col_n_q <= ~(4'b0001 << (col_q + 2'd1));
                snap_q  <= snap_d;
            end else begin
                dwell_q <= dwell_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            held_q  <= 1'b0;
        end else if (frame_end) begin
            case (state_q)
                S_IDLE: begin
                    if (single) begin
                        code_q <= cand;
                        if (DEB_N == 4'd1) begin
                            state_q <= S_PRESSED;
                            held_q  <= 1'b1;
                        end else begin
                            state_q <= S_DEB;
                            cnt_q   <= 4'd1;
                        end
                    end
                end
                S_DEB: begin
                    if (single && cand == code_q) begin
                        if (cnt_q + 4'd1 == DEB_N) begin
                            state_q <= S_PRESSED;
                            held_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_PRESSED: begin
                    if (none) begin
                        if (DEB_N == 4'd1) begin
                            state_q <= S_IDLE;
                            held_q  <= 1'b0;
                        end else begin
                            state_q <= S_RELEASE;
                            cnt_q   <= 4'd1;
                        end
                    end
                end
                default: begin
                    if (none) begin
                        if (cnt_q + 4'd1 == DEB_N) begin
                            state_q <= S_IDLE;
                            held_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end else begin
                        // Bounce during release: back to held, no new accept.
                        state_q <= S_PRESSED;
                    end
                end
            endcase
        end
    end

    // Handshake: an accept always wins over a same-cycle ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (accept) begin
            if (!key_valid_q) begin
                key_code_q  <= cand;
                key_valid_q <= 1'b1;
            end else if (kp.key_ack) begin
                key_code_q <= cand;
                overrun_q  <= 1'b0;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (key_valid_q && kp.key_ack) begin
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end
    end

    assign kp.col_n     = col_n_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = held_q;
    assign kp.overrun   = overrun_q;
endmodule
